// File: rtl/mem_arb_pkg.sv
// Shared types for the main-memory arbiter: FSM states, requester ids and memory op codes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Requester ids double as bit positions in the picker's req/grant vectors.
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/main_mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: grants the sole requester, or on a tie the one that was not last.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req[REQ_I] && (!req[REQ_D] || last == REQ_D)) begin
            grant[REQ_I] = 1'b1;
        end else if (req[REQ_D]) begin
            grant[REQ_D] = 1'b1;
        end
    end

endmodule

// File: rtl/main_mem_arbiter.sv
// Shares one main-memory block port between the I-cache (refills) and D-cache (refills, write-backs).
// A granted command is latched and held until memory completes; strobes are derived from latched state.
module main_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 28,
    parameter int BLOCK_WIDTH = 128
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   I_MEM_READ,
    input  logic [ADDR_WIDTH-1:0]  I_MEM_ADDRESS,
    output logic [BLOCK_WIDTH-1:0] I_MEM_READ_DATA,
    output logic                   I_MEM_BUSY_WAIT,
    input  logic                   D_MEM_READ,
    input  logic                   D_MEM_WRITE,
    input  logic [ADDR_WIDTH-1:0]  D_MEM_ADDRESS,
    input  logic [BLOCK_WIDTH-1:0] D_MEM_WRITE_DATA,
    output logic [BLOCK_WIDTH-1:0] D_MEM_READ_DATA,
    output logic                   D_MEM_BUSY_WAIT,
    output logic                   MAIN_MEM_READ,
    output logic                   MAIN_MEM_WRITE,
    output logic [ADDR_WIDTH-1:0]  MAIN_MEM_ADDRESS,
    output logic [BLOCK_WIDTH-1:0] MAIN_MEM_WRITE_DATA,
    input  logic [BLOCK_WIDTH-1:0] MAIN_MEM_READ_DATA,
    input  logic                   MAIN_MEM_BUSY_WAIT,
    output state_t                 dbg_state
);

    state_t                 state_q;
    op_t                    op_q;
    logic                   last_q;
    logic                   started_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [BLOCK_WIDTH-1:0] wdata_q;

    logic       req_i;
    logic       req_d;
    logic [1:0] pick;
    logic       granted;
    logic       done;

    assign req_i = I_MEM_READ;
    assign req_d = D_MEM_READ | D_MEM_WRITE;

    rr_pick2 u_pick (
        .req   ({req_d, req_i}),
        .last  (last_q),
        .grant (pick)
    );

    assign granted = (state_q == GRANT_I) || (state_q == GRANT_D);
    // Busy low before memory has ever raised busy is just latency, not completion.
    assign done    = granted & started_q & !MAIN_MEM_BUSY_WAIT;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= OP_READ;
            last_q    <= REQ_D;
            started_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick[REQ_I]) begin
                        state_q <= GRANT_I;
                        op_q    <= OP_READ;
                        addr_q  <= I_MEM_ADDRESS;
                        last_q  <= REQ_I;
                    end else if (pick[REQ_D]) begin
                        state_q <= GRANT_D;
                        addr_q  <= D_MEM_ADDRESS;
                        last_q  <= REQ_D;
                        // Write wins when the D-cache illegally raises both strobes.
                        if (D_MEM_WRITE) begin
                            op_q    <= OP_WRITE;
                            wdata_q <= D_MEM_WRITE_DATA;
                        end else begin
                            op_q <= OP_READ;
                        end
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (done) begin
                        state_q   <= RELEASE;
                        started_q <= 1'b0;
                    end else if (MAIN_MEM_BUSY_WAIT) begin
                        started_q <= 1'b1;
                    end
                end
                RELEASE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign MAIN_MEM_READ       = granted & (op_q == OP_READ);
    assign MAIN_MEM_WRITE      = granted & (op_q == OP_WRITE);
    assign MAIN_MEM_ADDRESS    = addr_q;
    assign MAIN_MEM_WRITE_DATA = wdata_q;

    // A dropped request simply sees busy low; the latched command still runs to completion.
    assign I_MEM_BUSY_WAIT = req_i & !((state_q == GRANT_I) & done);
    assign D_MEM_BUSY_WAIT = req_d & !((state_q == GRANT_D) & done);

    assign I_MEM_READ_DATA = MAIN_MEM_READ_DATA;
    assign D_MEM_READ_DATA = MAIN_MEM_READ_DATA;

    assign dbg_state = state_q;

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Bench for main_mem_arbiter: directed vectors and corner sequences, then random I/D traffic
// scored against a shadow memory model with a behavioural main memory.
module tb_main_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 28;
    localparam int BW = 128;
    localparam logic [BW-1:0] BAD_DATA = {8{16'hBADD}};

    logic          clock = 1'b0;
    logic          reset;
    logic          I_MEM_READ;
    logic [AW-1:0] I_MEM_ADDRESS;
    logic [BW-1:0] I_MEM_READ_DATA;
    logic          I_MEM_BUSY_WAIT;
    logic          D_MEM_READ;
    logic          D_MEM_WRITE;
    logic [AW-1:0] D_MEM_ADDRESS;
    logic [BW-1:0] D_MEM_WRITE_DATA;
    logic [BW-1:0] D_MEM_READ_DATA;
    logic          D_MEM_BUSY_WAIT;
    logic          MAIN_MEM_READ;
    logic          MAIN_MEM_WRITE;
    logic [AW-1:0] MAIN_MEM_ADDRESS;
    logic [BW-1:0] MAIN_MEM_WRITE_DATA;
    logic [BW-1:0] MAIN_MEM_READ_DATA;
    logic          MAIN_MEM_BUSY_WAIT;
    state_t        dbg_state;

    int errors = 0;
    int checks = 0;

    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] mem_store[logic [AW-1:0]];
    logic [BW-1:0] d_shadow[logic [AW-1:0]];

    int mem_pre  = 0;
    int mem_len  = 2;
    bit mem_rand = 1'b0;

    main_mem_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
        .clock               (clock),
        .reset               (reset),
        .I_MEM_READ          (I_MEM_READ),
        .I_MEM_ADDRESS       (I_MEM_ADDRESS),
        .I_MEM_READ_DATA     (I_MEM_READ_DATA),
        .I_MEM_BUSY_WAIT     (I_MEM_BUSY_WAIT),
        .D_MEM_READ          (D_MEM_READ),
        .D_MEM_WRITE         (D_MEM_WRITE),
        .D_MEM_ADDRESS       (D_MEM_ADDRESS),
        .D_MEM_WRITE_DATA    (D_MEM_WRITE_DATA),
        .D_MEM_READ_DATA     (D_MEM_READ_DATA),
        .D_MEM_BUSY_WAIT     (D_MEM_BUSY_WAIT),
        .MAIN_MEM_READ       (MAIN_MEM_READ),
        .MAIN_MEM_WRITE      (MAIN_MEM_WRITE),
        .MAIN_MEM_ADDRESS    (MAIN_MEM_ADDRESS),
        .MAIN_MEM_WRITE_DATA (MAIN_MEM_WRITE_DATA),
        .MAIN_MEM_READ_DATA  (MAIN_MEM_READ_DATA),
        .MAIN_MEM_BUSY_WAIT  (MAIN_MEM_BUSY_WAIT),
        .dbg_state           (dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [BW-1:0] mem_default(input logic [AW-1:0] a);
        return {a, 84'h0, 16'hDEAD};
    endfunction

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sample and drive point: 2 ns after the falling edge.
    task automatic tick();
        @(negedge clock);
        #2;
    endtask

    task automatic wait_busy_low(input bit is_d, input int limit, output int cycles,
                                 output bit ok, output bit other_low);
        cycles = 0;
        ok = 1'b0;
        other_low = 1'b0;
        while (!ok && cycles < limit) begin
            tick();
            cycles++;
            if (is_d) begin
                ok = !D_MEM_BUSY_WAIT;
                if (I_MEM_READ && !I_MEM_BUSY_WAIT) other_low = 1'b1;
            end else begin
                ok = !I_MEM_BUSY_WAIT;
                if ((D_MEM_READ || D_MEM_WRITE) && !D_MEM_BUSY_WAIT) other_low = 1'b1;
            end
        end
        check(is_d ? "d_done_in_time" : "i_done_in_time", 128'(ok), 128'd1);
    endtask

    // Behavioural main memory: optional busy-low delay, busy for len cycles, then one completion cycle.
    initial begin : main_memory
        logic [AW-1:0] a;
        logic [BW-1:0] wd;
        logic          w;
        int            pre;
        int            len;
        MAIN_MEM_BUSY_WAIT = 1'b0;
        MAIN_MEM_READ_DATA = BAD_DATA;
        forever begin
            @(negedge clock);
            if (!reset && (MAIN_MEM_READ || MAIN_MEM_WRITE)) begin
                a  = MAIN_MEM_ADDRESS;
                w  = MAIN_MEM_WRITE;
                wd = MAIN_MEM_WRITE_DATA;
                check("mem_one_strobe", 128'(MAIN_MEM_READ & MAIN_MEM_WRITE), 128'd0);
                pre = mem_rand ? int'($urandom_range(0, 1)) : mem_pre;
                len = mem_rand ? int'($urandom_range(1, 4)) : mem_len;
                repeat (pre) @(negedge clock);
                MAIN_MEM_BUSY_WAIT = 1'b1;
                repeat (len) @(negedge clock);
                if (MAIN_MEM_READ || MAIN_MEM_WRITE) begin
                    check("mem_addr_held", 128'(MAIN_MEM_ADDRESS), 128'(a));
                    check("mem_op_held", 128'(MAIN_MEM_WRITE), 128'(w));
                end
                if (w) mem_store[a] = wd;
                else MAIN_MEM_READ_DATA = mem_store.exists(a) ? mem_store[a] : mem_default(a);
                MAIN_MEM_BUSY_WAIT = 1'b0;
                @(negedge clock);
                MAIN_MEM_READ_DATA = BAD_DATA;
            end
        end
    end

    // driver tasks for the random phase
    task automatic i_agent(input int n);
        int cyc;
        bit ok;
        bit ol;
        logic [BW-1:0] e;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            I_MEM_ADDRESS = 28'($urandom_range(32'h1000, 32'hFFFF));
            I_MEM_READ = 1'b1;
            exp_q.push_back(mem_default(I_MEM_ADDRESS));
            wait_busy_low(1'b0, 40, cyc, ok, ol);
            check("rnd_i_wait_bound", 128'(cyc <= 20), 128'd1);
            e = exp_q.pop_front();
            if (ok) check("rnd_i_data", I_MEM_READ_DATA, e);
            I_MEM_READ = 1'b0;
            tick();
        end
    endtask

    task automatic d_agent(input int n);
        int cyc;
        bit ok;
        bit ol;
        bit wr;
        logic [AW-1:0] a;
        logic [BW-1:0] wd;
        logic [BW-1:0] e;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            a  = 28'h8000000 | 28'($urandom_range(0, 7));
            wr = 1'($urandom_range(0, 1));
            wd = {$urandom, $urandom, $urandom, $urandom};
            e  = d_shadow.exists(a) ? d_shadow[a] : mem_default(a);
            D_MEM_ADDRESS    = a;
            D_MEM_WRITE_DATA = wd;
            D_MEM_WRITE      = wr;
            D_MEM_READ       = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            wait_busy_low(1'b1, 40, cyc, ok, ol);
            check("rnd_d_wait_bound", 128'(cyc <= 20), 128'd1);
            if (ok && wr) d_shadow[a] = wd;
            if (ok && !wr) check("rnd_d_data", D_MEM_READ_DATA, e);
            D_MEM_READ  = 1'b0;
            D_MEM_WRITE = 1'b0;
            tick();
        end
    endtask

    typedef struct {
        logic i_rd;
        logic d_rd;
        logic d_wr;
        logic exp_rd;
        logic exp_wr;
        logic exp_d;
    } vec_t;

    initial begin : main_test
        vec_t          vecs[7];
        int            cyc;
        bit            ok;
        bit            ol;
        logic [BW-1:0] wd;
        logic [AW-1:0] ia;
        logic [AW-1:0] da;
        bit            owners[$];
        int            gaps[$];
        int            d_phase;
        int            low_run;
        bit            prev_strobe;
        bit            strobe;
        bit            first;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        reset = 1'b1;
        I_MEM_READ = 1'b0;
        I_MEM_ADDRESS = '0;
        D_MEM_READ = 1'b0;
        D_MEM_WRITE = 1'b0;
        D_MEM_ADDRESS = '0;
        D_MEM_WRITE_DATA = '0;
        repeat (2) tick();
        check("rst_read", 128'(MAIN_MEM_READ), 128'd0);
        check("rst_write", 128'(MAIN_MEM_WRITE), 128'd0);
        check("rst_addr", 128'(MAIN_MEM_ADDRESS), 128'd0);
        check("rst_wdata", MAIN_MEM_WRITE_DATA, 128'd0);
        check("rst_state", 128'(dbg_state), 128'(IDLE));
        check("rst_busy", 128'({I_MEM_BUSY_WAIT, D_MEM_BUSY_WAIT}), 128'd0);
        reset = 1'b0;

        // Reset in the middle of a D write
        mem_pre = 0;
        mem_len = 3;
        D_MEM_WRITE = 1'b1;
        D_MEM_ADDRESS = 28'h30;
        D_MEM_WRITE_DATA = {4{$urandom}};
        tick();
        check("t1_write_strobe", 128'(MAIN_MEM_WRITE), 128'd1);
        I_MEM_READ = 1'b1;
        tick();
        #1 reset = 1'b1;
        #1;
        check("t1_rst_write", 128'(MAIN_MEM_WRITE), 128'd0);
        check("t1_rst_state", 128'(dbg_state), 128'(IDLE));
        check("t1_rst_busy", 128'({I_MEM_BUSY_WAIT, D_MEM_BUSY_WAIT}), 128'b11);
        I_MEM_READ = 1'b0;
        D_MEM_WRITE = 1'b0;
        tick();
        reset = 1'b0;
        repeat (6) tick();

        // Lone I read, memory busy for 5 cycles
        mem_len = 5;
        I_MEM_ADDRESS = 28'h10;
        I_MEM_READ = 1'b1;
        tick();
        check("t2_read_strobe", 128'(MAIN_MEM_READ), 128'd1);
        check("t2_addr", 128'(MAIN_MEM_ADDRESS), 128'h10);
        check("t2_busy_high", 128'(I_MEM_BUSY_WAIT), 128'd1);
        wait_busy_low(1'b0, 12, cyc, ok, ol);
        check("t2_latency", 128'(cyc), 128'd5);
        check("t2_data", I_MEM_READ_DATA, mem_default(28'h10));
        tick();
        check("t2_busy_again", 128'(I_MEM_BUSY_WAIT), 128'd1);
        check("t2_release", 128'(dbg_state), 128'(RELEASE));
        check("t2_strobe_off", 128'(MAIN_MEM_READ), 128'd0);
        I_MEM_READ = 1'b0;
        tick();

        // Arbitration vectors; round-robin history carries from one vector to the next
        mem_len = 2;
        for (int k = 0; k < 7; k++) begin
            ia = 28'h100 + 28'(k);
            da = 28'h8000100 + 28'(k);
            wd = {$urandom, $urandom, $urandom, $urandom};
            I_MEM_ADDRESS = ia;
            D_MEM_ADDRESS = da;
            D_MEM_WRITE_DATA = wd;
            I_MEM_READ = vecs[k].i_rd;
            D_MEM_READ = vecs[k].d_rd;
            D_MEM_WRITE = vecs[k].d_wr;
            tick();
            check($sformatf("v%0d_rd", k), 128'(MAIN_MEM_READ), 128'(vecs[k].exp_rd));
            check($sformatf("v%0d_wr", k), 128'(MAIN_MEM_WRITE), 128'(vecs[k].exp_wr));
            check($sformatf("v%0d_addr", k), 128'(MAIN_MEM_ADDRESS), 128'(vecs[k].exp_d ? da : ia));
            wait_busy_low(vecs[k].exp_d, 20, cyc, ok, ol);
            check($sformatf("v%0d_other_busy", k), 128'(ol), 128'd0);
            if (vecs[k].exp_rd)
                check($sformatf("v%0d_rdata", k), vecs[k].exp_d ? D_MEM_READ_DATA : I_MEM_READ_DATA,
                      mem_default(vecs[k].exp_d ? da : ia));
            I_MEM_READ = 1'b0;
            D_MEM_READ = 1'b0;
            D_MEM_WRITE = 1'b0;
            tick();
            check($sformatf("v%0d_release", k), 128'(dbg_state), 128'(RELEASE));
            check($sformatf("v%0d_wr_stored", k), mem_store.exists(da) ? mem_store[da] : 128'd0,
                  vecs[k].exp_wr ? wd : 128'd0);
            tick();
        end

        // Simultaneous I and D reads straight after reset: I first, D next
        reset = 1'b1;
        tick();
        reset = 1'b0;
        I_MEM_ADDRESS = 28'h200;
        D_MEM_ADDRESS = 28'h8000200;
        I_MEM_READ = 1'b1;
        D_MEM_READ = 1'b1;
        tick();
        check("t3_first_addr", 128'(MAIN_MEM_ADDRESS), 128'h200);
        wait_busy_low(1'b0, 20, cyc, ok, ol);
        check("t3_d_busy_during_i", 128'(ol), 128'd0);
        check("t3_i_data", I_MEM_READ_DATA, mem_default(28'h200));
        I_MEM_READ = 1'b0;
        tick();
        check("t3_d_busy_release", 128'(D_MEM_BUSY_WAIT), 128'd1);
        tick();
        tick();
        check("t3_second_addr", 128'(MAIN_MEM_ADDRESS), 128'h8000200);
        check("t3_second_read", 128'(MAIN_MEM_READ), 128'd1);
        wait_busy_low(1'b1, 20, cyc, ok, ol);
        check("t3_d_data", D_MEM_READ_DATA, mem_default(28'h8000200));
        D_MEM_READ = 1'b0;
        repeat (2) tick();

        // D write with memory busy low for one cycle after the strobe
        mem_pre = 1;
        mem_len = 2;
        D_MEM_ADDRESS = 28'h20;
        D_MEM_WRITE_DATA = {16{8'hA5}};
        D_MEM_WRITE = 1'b1;
        tick();
        check("t4_write_strobe", 128'(MAIN_MEM_WRITE), 128'd1);
        check("t4_wdata", MAIN_MEM_WRITE_DATA, {16{8'hA5}});
        tick();
        check("t4_no_early_done", 128'(D_MEM_BUSY_WAIT), 128'd1);
        wait_busy_low(1'b1, 12, cyc, ok, ol);
        check("t4_latency", 128'(cyc), 128'd2);
        check("t4_stored", mem_store.exists(28'h20) ? mem_store[28'h20] : 128'd0, {16{8'hA5}});
        D_MEM_WRITE = 1'b0;
        repeat (2) tick();

        // D drops its write mid-transaction and scribbles on address/data
        mem_pre = 0;
        mem_len = 4;
        wd = {$urandom, $urandom, $urandom, $urandom};
        D_MEM_ADDRESS = 28'h8000050;
        D_MEM_WRITE_DATA = wd;
        D_MEM_WRITE = 1'b1;
        tick();
        check("t5_write_strobe", 128'(MAIN_MEM_WRITE), 128'd1);
        tick();
        D_MEM_WRITE = 1'b0;
        D_MEM_ADDRESS = 28'h1234567;
        D_MEM_WRITE_DATA = '0;
        ok = 1'b0;
        for (int c = 0; c < 10 && !ok; c++) begin
            tick();
            if (dbg_state == RELEASE) begin
                ok = 1'b1;
            end else begin
                check("t5_write_held", 128'(MAIN_MEM_WRITE), 128'd1);
                check("t5_addr_held", 128'(MAIN_MEM_ADDRESS), 128'h8000050);
                check("t5_no_d_busy", 128'(D_MEM_BUSY_WAIT), 128'd0);
            end
        end
        check("t5_reached_release", 128'(ok), 128'd1);
        check("t5_strobe_off", 128'({MAIN_MEM_READ, MAIN_MEM_WRITE}), 128'd0);
        check("t5_stored", mem_store.exists(28'h8000050) ? mem_store[28'h8000050] : 128'd0, wd);
        tick();

        // I requests continuously while D does a write then a read: strict alternation
        mem_len = 2;
        wd = {$urandom, $urandom, $urandom, $urandom};
        I_MEM_ADDRESS = 28'h300;
        I_MEM_READ = 1'b1;
        D_MEM_ADDRESS = 28'h8000060;
        D_MEM_WRITE_DATA = wd;
        D_MEM_WRITE = 1'b1;
        d_phase = 0;
        low_run = 0;
        prev_strobe = 1'b0;
        first = 1'b1;
        for (int c = 0; c < 80 && !(d_phase == 2 && owners.size() >= 5); c++) begin
            tick();
            strobe = MAIN_MEM_READ | MAIN_MEM_WRITE;
            if (strobe && !prev_strobe) begin
                owners.push_back(MAIN_MEM_ADDRESS[AW-1]);
                if (!first) gaps.push_back(low_run);
                first = 1'b0;
            end
            low_run = strobe ? 0 : low_run + 1;
            prev_strobe = strobe;
            if (!I_MEM_BUSY_WAIT) check("t6_i_data", I_MEM_READ_DATA, mem_default(28'h300));
            if (d_phase < 2 && !D_MEM_BUSY_WAIT) begin
                if (d_phase == 0) begin
                    D_MEM_WRITE = 1'b0;
                    D_MEM_READ = 1'b1;
                    d_phase = 1;
                end else begin
                    check("t6_d_readback", D_MEM_READ_DATA, wd);
                    D_MEM_READ = 1'b0;
                    d_phase = 2;
                end
            end
        end
        check("t6_owner_count", 128'(owners.size() >= 5), 128'd1);
        for (int k = 0; k < 5; k++)
            if (k < owners.size()) check($sformatf("t6_owner%0d", k), 128'(owners[k]), 128'(k % 2));
        for (int k = 0; k < 4; k++)
            if (k < gaps.size()) check($sformatf("t6_gap%0d", k), 128'(gaps[k]), 128'd2);
        I_MEM_READ = 1'b0;
        repeat (8) tick();

        // Random concurrent traffic
        mem_rand = 1'b1;
        fork
            i_agent(30);
            d_agent(30);
        join
        mem_rand = 1'b0;
        repeat (8) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
